// File: rtl/uart_rcvr_if.sv
// rtl/uart_rcvr_if.sv - host-side signal bundle between the UART receiver and its line/host
interface uart_rcvr_if #(
  parameter int word_size = 8
);
  logic                 Serial_in;
  logic                 Read_done;
  logic [word_size-1:0] Data_out;
  logic                 Data_ready;
  logic                 Error_overrun;
  logic                 Error_frame;

  // line driver / host side
  modport master (
    output Serial_in,
    output Read_done,
    input  Data_out,
    input  Data_ready,
    input  Error_overrun,
    input  Error_frame
  );

  // receiver side
  modport slave (
    input  Serial_in,
    input  Read_done,
    output Data_out,
    output Data_ready,
    output Error_overrun,
    output Error_frame
  );
endinterface

// File: rtl/uart_rcvr.sv
// rtl/uart_rcvr.sv - oversampling UART receiver with sticky overrun/framing flags; UART_RCVR_MAJORITY_EN selects 2-of-3 bit voting
module uart_rcvr #(
  parameter int word_size    = 8,
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       Clock,
  input  logic       rst_b,
  uart_rcvr_if.slave bus
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(word_size + 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(word_size - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bit_idx, bit_idx_n;
  logic [word_size-1:0] shreg, shreg_n;
  logic [word_size-1:0] dout_n;
  logic                 rdy_n, ovr_n, frm_n;
  logic [1:0]           sync;
  logic                 rx_s;
  logic                 bit_val;

  assign rx_s = sync[1];

  // two-flop synchronizer for the asynchronous serial line, idles high
  always_ff @(posedge Clock or negedge rst_b) begin
    if (!rst_b) sync <= 2'b11;
    else        sync <= {sync[0], bus.Serial_in};
  end

`ifdef UART_RCVR_MAJORITY_EN
  localparam logic [CW-1:0] CNT_V0 = CW'(CLKS_PER_BIT - 3);
  localparam logic [CW-1:0] CNT_V1 = CW'(CLKS_PER_BIT - 2);
  logic [1:0] vote;

  // capture the two early votes of each data/stop bit; the third is rx_s itself
  always_ff @(posedge Clock or negedge rst_b) begin
    if (!rst_b) begin
      vote <= 2'b00;
    end else if (state == S_DATA || state == S_STOP) begin
      if (cnt == CNT_V0) vote[0] <= rx_s;
      if (cnt == CNT_V1) vote[1] <= rx_s;
    end
  end

  assign bit_val = (vote[0] & vote[1]) | (vote[0] & rx_s) | (vote[1] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  // state, counters, shift register and host-visible registers
  always_ff @(posedge Clock or negedge rst_b) begin
    if (!rst_b) begin
      state             <= S_IDLE;
      cnt               <= '0;
      bit_idx           <= '0;
      shreg             <= '0;
      bus.Data_out      <= '0;
      bus.Data_ready    <= 1'b0;
      bus.Error_overrun <= 1'b0;
      bus.Error_frame   <= 1'b0;
    end else begin
      state             <= state_n;
      cnt               <= cnt_n;
      bit_idx           <= bit_idx_n;
      shreg             <= shreg_n;
      bus.Data_out      <= dout_n;
      bus.Data_ready    <= rdy_n;
      bus.Error_overrun <= ovr_n;
      bus.Error_frame   <= frm_n;
    end
  end

  // frame sequencing; a load or framing error in the same cycle overrides the Read_done clear
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    dout_n    = bus.Data_out;
    rdy_n     = bus.Data_ready;
    ovr_n     = bus.Error_overrun;
    frm_n     = bus.Error_frame;

    if (bus.Read_done) begin
      rdy_n = 1'b0;
      ovr_n = 1'b0;
      frm_n = 1'b0;
    end

    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_n = S_START;
          cnt_n   = '0;
        end
      end
      S_START: begin
        if (cnt == CNT_HALF) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt == CNT_LAST) begin
          shreg_n   = {bit_val, shreg[word_size-1:1]};
          cnt_n     = '0;
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == IDX_LAST) state_n = S_STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (bit_val) begin
            dout_n = shreg;
            rdy_n  = 1'b1;
            if (bus.Data_ready && !bus.Read_done) ovr_n = 1'b1;
            state_n = S_IDLE;
          end else begin
            frm_n   = 1'b1;
            state_n = S_BREAK;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_BREAK: begin
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end
endmodule
